// File: rtl/spi_host_master.sv
// SPI initiator for the on-chip AES frame target and LDO gain target.
// It divides clk down to sclk, shifts command frames out MSB-first and captures the AES response frame.
module spi_host_master #(
    parameter int CLK_DIV      = 2,
    parameter int AES_BITS     = 131,
    parameter int AES_RSP_BITS = 130,
    parameter int LDO_BITS     = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         aes_req,
    input  logic         aes_valid_in,
    input  logic [127:0] aes_data_in,
    input  logic         aes_encrypt_in,
    input  logic         aes_is_key,
    input  logic         ldo_req,
    input  logic [3:0]   ldo_p,
    input  logic [3:0]   ldo_i,
    input  logic [3:0]   ldo_d,
    output logic         busy,
    output logic         done,
    output logic         rsp_valid,
    output logic [127:0] rsp_data,
    output logic         rsp_encrypt,
    output logic         sclk,
    output logic         mosi,
    output logic         csel_AES,
    output logic         csel_LDO,
    input  logic         miso
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(AES_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_TRAIL,
        S_COMMIT_HI,
        S_COMMIT_LO,
        S_DONE
    } state_t;

    state_t                    state, state_d;
    logic [CW-1:0]             cnt, cnt_d;
    logic [BW-1:0]             bit_cnt, bit_cnt_d;
    logic                      is_aes, is_aes_d;
    logic [AES_BITS-1:0]       tx, tx_d;
    logic [AES_RSP_BITS-1:0]   rx;
    logic [AES_RSP_BITS-1:0]   rsp_q;
    logic                      capture;
    logic                      active_d;
    logic                      sclk_d, mosi_d, csel_aes_d, csel_ldo_d, busy_d, done_d;

    // Every timed phase lasts CLK_DIV cycles; the counter reloads on each phase change.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state;
        bit_cnt_d = bit_cnt;
        is_aes_d  = is_aes;
        tx_d      = tx;
        unique case (state)
            S_IDLE: begin
                if (aes_req || ldo_req) begin
                    state_d   = S_SETUP;
                    is_aes_d  = aes_req;
                    bit_cnt_d = aes_req ? BW'(AES_BITS - 1) : BW'(LDO_BITS - 1);
                    tx_d      = aes_req ? {aes_valid_in, aes_data_in, aes_encrypt_in, aes_is_key}
                                        : {ldo_p, ldo_i, ldo_d, {(AES_BITS - LDO_BITS){1'b0}}};
                end
            end
            S_SETUP:     if (cnt == '0) state_d = S_SHIFT_HI;
            S_SHIFT_HI: begin
                if (cnt == '0) begin
                    state_d = S_SHIFT_LO;
                    tx_d    = tx << 1;
                end
            end
            S_SHIFT_LO: begin
                if (cnt == '0) begin
                    if (bit_cnt == '0) begin
                        state_d = S_TRAIL;
                    end else begin
                        state_d   = S_SHIFT_HI;
                        bit_cnt_d = bit_cnt - 1'b1;
                    end
                end
            end
            S_TRAIL:     if (cnt == '0) state_d = S_COMMIT_HI;
            S_COMMIT_HI: if (cnt == '0) state_d = S_COMMIT_LO;
            S_COMMIT_LO: if (cnt == '0) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state || state == S_IDLE) ? CW'(CLK_DIV - 1) : cnt - 1'b1;
    end

    // Pin values are decoded from the next state and registered, so sclk and csel never glitch.
    always_comb begin
        active_d   = (state_d == S_SETUP) || (state_d == S_SHIFT_HI) || (state_d == S_SHIFT_LO);
        sclk_d     = (state_d == S_SHIFT_HI) || (state_d == S_COMMIT_HI);
        mosi_d     = active_d & tx_d[AES_BITS-1];
        csel_aes_d = active_d & is_aes_d;
        csel_ldo_d = active_d & ~is_aes_d;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // miso is taken on every sclk rise except the first, i.e. on each SHIFT_LO -> SHIFT_HI edge.
    assign capture = is_aes && (state == S_SHIFT_LO) && (state_d == S_SHIFT_HI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            is_aes   <= 1'b0;
            tx       <= '0;
            rx       <= '0;
            rsp_q    <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            csel_AES <= 1'b0;
            csel_LDO <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_cnt_d;
            is_aes   <= is_aes_d;
            tx       <= tx_d;
            if (capture)
                rx <= {rx[AES_RSP_BITS-2:0], miso};
            if (state_d == S_DONE && is_aes)
                rsp_q <= rx;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
            csel_AES <= csel_aes_d;
            csel_LDO <= csel_ldo_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    assign rsp_valid   = rsp_q[AES_RSP_BITS-1];
    assign rsp_data    = rsp_q[AES_RSP_BITS-2:1];
    assign rsp_encrypt = rsp_q[0];

endmodule

// File: tb/tb_spi_host_master.sv
// Self-checking bench for spi_host_master: table vectors, random frames against SPI target models,
// mid-frame reset and a CLK_DIV=1 instance.
module tb_spi_host_master;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         aes_req = 1'b0, ldo_req = 1'b0, aes_req1 = 1'b0, ldo_req1 = 1'b0;
    logic         aes_valid_in = 1'b0, aes_encrypt_in = 1'b0, aes_is_key = 1'b0;
    logic [127:0] aes_data_in = '0;
    logic [3:0]   ldo_p = '0, ldo_i = '0, ldo_d = '0;
    logic         miso = 1'b0;
    logic         busy, done, rsp_valid, rsp_encrypt, sclk, mosi, csel_AES, csel_LDO;
    logic [127:0] rsp_data;
    logic         busy1, done1, rsp_valid1, rsp_encrypt1, sclk1, mosi1, csel_AES1, csel_LDO1;
    logic [127:0] rsp_data1;

    always #5 clk = ~clk;

    spi_host_master #(.CLK_DIV(2)) dut (
        .clk(clk), .reset_n(reset_n), .aes_req(aes_req), .aes_valid_in(aes_valid_in),
        .aes_data_in(aes_data_in), .aes_encrypt_in(aes_encrypt_in), .aes_is_key(aes_is_key),
        .ldo_req(ldo_req), .ldo_p(ldo_p), .ldo_i(ldo_i), .ldo_d(ldo_d), .busy(busy), .done(done),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_encrypt(rsp_encrypt), .sclk(sclk),
        .mosi(mosi), .csel_AES(csel_AES), .csel_LDO(csel_LDO), .miso(miso)
    );

    spi_host_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .aes_req(aes_req1), .aes_valid_in(aes_valid_in),
        .aes_data_in(aes_data_in), .aes_encrypt_in(aes_encrypt_in), .aes_is_key(aes_is_key),
        .ldo_req(ldo_req1), .ldo_p(ldo_p), .ldo_i(ldo_i), .ldo_d(ldo_d), .busy(busy1), .done(done1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_encrypt(rsp_encrypt1), .sclk(sclk1),
        .mosi(mosi1), .csel_AES(csel_AES1), .csel_LDO(csel_LDO1), .miso(miso)
    );

    typedef struct {
        bit           is_aes;
        logic [3:0]   p, i, d;
        logic [130:0] frame;
        logic [129:0] rsp;      // target reply, and the rsp_* value expected at done for AES
        bit           both_req;
        bit           mid_ldo;
    } vec_t;

    int checks = 0, errors = 0;
    logic [129:0] exp_rsp = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI target models for the CLK_DIV=2 instance, sampled on the falling clk edge.
    logic [129:0] tgt_rsp = '0;
    logic [130:0] aes_cap = '0;
    logic [11:0]  ldo_cap = '0, ldo_latched = '0;
    logic         ps = 1'b0, pm = 1'b0, pa = 1'b0, pl = 1'b0, last_ldo = 1'b0;
    int aes_edges = 0, ldo_edges = 0, commits = 0, aes_frames = 0, ldo_frames = 0;
    int mosi_err = 0, glitch_err = 0, neg_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (csel_AES && !pa) begin
            aes_frames++; aes_edges = 0; aes_cap = '0; neg_cnt = 0; commits = 0; last_ldo = 1'b0;
        end
        if (csel_LDO && !pl) begin
            ldo_frames++; ldo_edges = 0; ldo_cap = '0; commits = 0; last_ldo = 1'b1;
        end
        if (csel_AES && csel_LDO) glitch_err++;
        if ((csel_AES !== pa || csel_LDO !== pl) && (sclk || ps)) glitch_err++;
        if ((csel_AES || csel_LDO) && (pa || pl) && mosi !== pm && !(!sclk && ps)) mosi_err++;
        if (sclk && !ps) begin
            if (csel_AES) begin
                aes_cap = {aes_cap[129:0], mosi}; aes_edges++;
            end else if (csel_LDO) begin
                ldo_cap = {ldo_cap[10:0], mosi}; ldo_edges++;
            end else begin
                commits++;
                if (last_ldo) ldo_latched = ldo_cap;
            end
        end
        if (!sclk && ps && csel_AES) begin
            miso = (neg_cnt < 130) ? tgt_rsp[129 - neg_cnt] : 1'b0;
            neg_cnt++;
        end
        if (done) done_cnt++;
        ps = sclk; pm = mosi; pa = csel_AES; pl = csel_LDO;
    end

    task automatic run(input vec_t v);
        int n, exp_lat, lat, af0, lf0, me0, ge0, dc0;
        n = v.is_aes ? 131 : 12;
        exp_lat = (2 * n + 4) * 2;
        af0 = aes_frames; lf0 = ldo_frames; me0 = mosi_err; ge0 = glitch_err;
        tgt_rsp = v.rsp;
        @(posedge clk); #1;
        {aes_valid_in, aes_data_in, aes_encrypt_in, aes_is_key} = v.frame;
        {ldo_p, ldo_i, ldo_d} = {v.p, v.i, v.d};
        aes_req = v.is_aes;
        ldo_req = !v.is_aes || v.both_req;
        @(posedge clk); #1;
        aes_req = 1'b0; ldo_req = 1'b0;
        dc0 = done_cnt;
        // Inputs changing after the accept edge must not reach the wire.
        aes_data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        aes_valid_in = ~aes_valid_in; aes_is_key = ~aes_is_key;
        ldo_p = ~ldo_p; ldo_i = ~ldo_i; ldo_d = ~ldo_d;
        check("busy_after_accept", busy, 1);
        lat = 0;
        while (done !== 1'b1 && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            ldo_req = (v.mid_ldo && lat == 100);
            if (lat == exp_lat - 1)
                check("rsp_held_before_done", {rsp_valid, rsp_data, rsp_encrypt}, exp_rsp);
        end
        ldo_req = 1'b0;
        check("done_latency", lat, exp_lat);
        check("busy_at_done", busy, 1);
        if (v.is_aes) exp_rsp = v.rsp;
        check("rsp_at_done", {rsp_valid, rsp_data, rsp_encrypt}, exp_rsp);
        if (v.is_aes) begin
            check("aes_target_frame", aes_cap, v.frame);
            check("aes_edge_count", aes_edges, 131);
        end else begin
            check("ldo_target_regs", ldo_latched, {v.p, v.i, v.d});
            check("ldo_edge_count", ldo_edges, 12);
        end
        check("commit_pulses", commits, 1);
        @(posedge clk); #1;
        check("done_one_cycle", {done, busy}, 0);
        repeat (20) @(posedge clk);
        #1;
        check("done_pulse_count", done_cnt - dc0, 1);
        check("aes_frames_started", aes_frames - af0, v.is_aes ? 1 : 0);
        check("ldo_frames_started", ldo_frames - lf0, v.is_aes ? 0 : 1);
        check("mosi_stable", mosi_err - me0, 0);
        check("no_glitch", glitch_err - ge0, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        logic [159:0] r;
        logic [11:0]  bits;
        int lat, edges, bad_period, unstable, last_rise, dc0;
        logic p1, m1;

        vecs[0] = '{is_aes: 1'b0, p: 4'hf, i: 4'ha, d: 4'hb, frame: '0, rsp: '0, both_req: 1'b0, mid_ldo: 1'b0};
        vecs[1] = '{is_aes: 1'b1, p: 4'h0, i: 4'h0, d: 4'h0,
                    frame: 131'h7_abcd_dead_beef_ceed_dead_beef_dead_beef,
                    rsp: {1'b1, 128'hdead_abcd_beed_ffff_beef_dead_dead_beef, 1'b1},
                    both_req: 1'b0, mid_ldo: 1'b0};
        vecs[2] = '{is_aes: 1'b1, p: 4'h3, i: 4'hc, d: 4'h5,
                    frame: 131'h2_0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                    rsp: {1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0},
                    both_req: 1'b1, mid_ldo: 1'b0};
        vecs[3] = '{is_aes: 1'b1, p: 4'h0, i: 4'h0, d: 4'h0,
                    frame: 131'h5_5555_5555_5555_5555_5555_5555_5555_5555,
                    rsp: {1'b1, 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969, 1'b0},
                    both_req: 1'b0, mid_ldo: 1'b1};
        vecs[4] = '{is_aes: 1'b0, p: 4'h1, i: 4'h0, d: 4'h8, frame: '0, rsp: '0, both_req: 1'b0, mid_ldo: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_pins", {busy, done, sclk, mosi, csel_AES, csel_LDO}, 0);
        check("reset_rsp", {rsp_valid, rsp_data, rsp_encrypt}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 5; k++) run(vecs[k]);

        // Reset around bit 60 of an AES frame abandons it immediately.
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        tgt_rsp = r[129:0];
        @(posedge clk); #1;
        {aes_valid_in, aes_data_in, aes_encrypt_in, aes_is_key} = r[130:0];
        aes_req = 1'b1;
        @(posedge clk); #1;
        aes_req = 1'b0;
        dc0 = done_cnt;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (aes_edges != 60 && lat < 1000);
        check("reset_reach_bit60", aes_edges, 60);
        reset_n = 1'b0;
        #1;
        check("reset_mid_frame_pins", {sclk, mosi, csel_AES, csel_LDO, busy, done}, 0);
        check("reset_mid_frame_rsp", {rsp_valid, rsp_data, rsp_encrypt}, 0);
        exp_rsp = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_no_done", done_cnt - dc0, 0);
        run(vecs[0]);

        // CLK_DIV=1 instance: 2-cycle sclk period, 28-cycle LDO transaction.
        @(posedge clk); #1;
        {ldo_p, ldo_i, ldo_d} = 12'hfab;
        ldo_req1 = 1'b1;
        @(posedge clk); #1;
        ldo_req1 = 1'b0;
        check("div1_busy_after_accept", busy1, 1);
        lat = 0; bits = '0; edges = 0; bad_period = 0; unstable = 0; last_rise = -1;
        p1 = sclk1; m1 = mosi1;
        while (done1 !== 1'b1 && lat < 500) begin
            @(posedge clk); #1;
            lat++;
            if (sclk1 && !p1 && csel_LDO1) begin
                bits = {bits[10:0], mosi1};
                edges++;
                if (mosi1 !== m1) unstable++;
                if (last_rise >= 0 && lat - last_rise != 2) bad_period++;
                last_rise = lat;
            end
            p1 = sclk1; m1 = mosi1;
        end
        check("div1_done_latency", lat, 28);
        check("div1_mosi_bits", bits, 12'hfab);
        check("div1_edge_count", edges, 12);
        check("div1_sclk_period", bad_period, 0);
        check("div1_mosi_stable", unstable, 0);
        check("div1_rsp_untouched", {rsp_valid1, rsp_data1, rsp_encrypt1}, 0);

        // Random frames and replies against the target models.
        for (int k = 0; k < 6; k++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            v.is_aes   = 1'($urandom_range(0, 1));
            v.frame    = r[130:0];
            r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            v.rsp      = r[129:0];
            v.p        = 4'($urandom()); v.i = 4'($urandom()); v.d = 4'($urandom());
            v.both_req = v.is_aes & 1'($urandom_range(0, 1));
            v.mid_ldo  = v.is_aes & 1'($urandom_range(0, 1));
            run(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
